// File: rtl/bin_to_bcd_4digits_pkg.sv
// Shared sizing constants and FSM encoding for the 4-digit binary-to-BCD
// converter. Consumers of packed BCD values can reuse the same constants.
package bin_to_bcd_4digits_pkg;

  localparam int NUM_DIGITS   = 4;
  localparam int BIN_W        = 14;
  localparam int BCD_W        = 4 * NUM_DIGITS;
  localparam int WORK_W       = BCD_W + BIN_W;
  localparam int MAX_VALUE    = 9999;
  localparam int SHIFT_CYCLES = 14;
  localparam int CNT_W        = 4;

  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VALUE);
  localparam logic [BCD_W-1:0] BCD_SAT  = 16'h9999;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when every nibble of a packed BCD word is a legal decimal digit.
  function automatic logic bcd_digits_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bin_to_bcd_4digits_digit_adjust.sv
// Double-dabble digit correction: a working BCD digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Add 3 to digits >= 5, pass smaller digits through.
  always_comb begin
    digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
  end

endmodule

// File: rtl/bin_to_bcd_4digits.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double-dabble).
// One conversion takes 14 SHIFT cycles followed by a single DONE cycle.
// Operands above 9999 saturate to 9999 and raise overflow.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; bcd/overflow hold the last result
//   ST_SHIFT | one adjust-and-shift step per cycle, 14 in total; start ignored
//   ST_DONE  | result registered, done pulses; start here chains directly
module bin_to_bcd_4digits
  import bin_to_bcd_4digits_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORK_W-1:0] work_q, work_d;
  // Sticky flag: captured operand was out of range, or a digit carried out
  // of the thousands position during shifting.
  logic              ovf_cap_q, ovf_cap_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              busy_q;
  logic              done_q;

  logic [BCD_W-1:0]  digits_adj;
  logic [WORK_W-1:0] work_shifted;
  logic              carry_out;
  logic [BCD_W-1:0]  final_digits;
  logic              final_sat;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (work_q[BIN_W + 4*g +: 4]),
      .digit_o (digits_adj[4*g +: 4])
    );
  end

  // Adjusted digits above the untouched binary part, shifted left by one.
  // The bit falling off the top is kept as carry_out.
  assign {carry_out, work_shifted} = {digits_adj, work_q[BIN_W-1:0], 1'b0};

  assign final_digits = work_shifted[WORK_W-1:BIN_W];
  assign final_sat    = ovf_cap_q | carry_out | ~bcd_digits_valid(final_digits);

  // Next-state, working register and result logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    ovf_cap_d = ovf_cap_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          work_d    = {{BCD_W{1'b0}}, bin};
          ovf_cap_d = (bin > MAX_BIN);
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        work_d    = work_shifted;
        ovf_cap_d = ovf_cap_q | carry_out;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          bcd_d   = final_sat ? BCD_SAT : final_digits;
          ovf_d   = final_sat;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      ovf_cap_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      ovf_cap_q <= ovf_cap_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= (state_d == ST_SHIFT);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bcd      = bcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
